// File: rtl/overlay_pkg.sv
// Shared types and colour helpers for the overlay pixel path.
// Colours are 6 bits: 2 bits each for R, G, B, from MSB to LSB.
package overlay_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_FADE_IN  = 3'd1,
    ST_HOLD     = 3'd2,
    ST_BLINK    = 3'd3,
    ST_FADE_OUT = 3'd4
  } seq_state_e;

  localparam logic [5:0] COLOR_BLACK = '0;

  localparam int unsigned CH_W  = 2;
  localparam int unsigned R_LSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_LSB = 0;

  // Subtract (3 - level) from one channel and stop at zero.
  function automatic logic [1:0] dim_channel(input logic [1:0] c, input logic [1:0] level);
    logic [1:0] sub;
    sub = 2'd3 - level;
    return (c > sub) ? (c - sub) : 2'd0;
  endfunction

endpackage

// File: rtl/rgb_dimmer.sv
// Combinational per-channel dimmer: level 3 passes colour through, level 0 gives black.
module rgb_dimmer
  import overlay_pkg::*;
(
  input  logic [5:0] rgb_i,
  input  logic [1:0] level_i,
  output logic [5:0] rgb_o
);

  always_comb begin
    rgb_o = COLOR_BLACK;
    rgb_o[R_LSB +: CH_W] = dim_channel(rgb_i[R_LSB +: CH_W], level_i);
    rgb_o[G_LSB +: CH_W] = dim_channel(rgb_i[G_LSB +: CH_W], level_i);
    rgb_o[B_LSB +: CH_W] = dim_channel(rgb_i[B_LSB +: CH_W], level_i);
  end

endmodule

// File: rtl/overlay_sequencer.sv
// Frame-synchronous emblem sequencer (OFF/FADE_IN/HOLD/BLINK/FADE_OUT) and pixel arbiter.
// All sequencing advances only on the registered vsync falling-edge tick.
module overlay_sequencer
  import overlay_pkg::*;
#(
  parameter int unsigned OFF_FRAMES       = 60,
  parameter int unsigned FADE_STEP_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES      = 120,
  parameter int unsigned BLINK_HALF       = 16,
  parameter int unsigned BLINK_COUNT      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       enable,
  input  logic       active,
  input  logic       emblem_draw,
  input  logic [5:0] emblem_rgb,
  input  logic       text_draw,
  input  logic [5:0] text_rgb,
  input  logic [5:0] bg_rgb,
  output logic [5:0] rgb_out,
  output logic [2:0] state_out,
  output logic [1:0] level_out,
  output logic       frame_tick
);

  localparam logic [7:0] OFF_LAST   = 8'(OFF_FRAMES - 1);
  localparam logic [7:0] STEP_LAST  = 8'(FADE_STEP_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] HALF_LAST  = 8'(BLINK_HALF - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_COUNT - 1);

  seq_state_e state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] blink_q, blink_d;
  logic       hidden_q, hidden_d;
  logic       vsync_q;
  logic       tick_q;
  logic [5:0] rgb_q, rgb_d;
  logic [5:0] dim_rgb;
  logic       emblem_vis;
  logic       abort;

  rgb_dimmer u_dimmer (
    .rgb_i   (emblem_rgb),
    .level_i (level_q),
    .rgb_o   (dim_rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      level_q  <= '0;
      cnt_q    <= '0;
      blink_q  <= '0;
      hidden_q <= 1'b0;
      vsync_q  <= 1'b1;
      tick_q   <= 1'b0;
      rgb_q    <= COLOR_BLACK;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      hidden_q <= hidden_d;
      vsync_q  <= vsync;
      tick_q   <= vsync_q & ~vsync;
      rgb_q    <= rgb_d;
    end
  end

  assign abort = ~enable & ((state_q == ST_FADE_IN) | (state_q == ST_HOLD) | (state_q == ST_BLINK));

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    hidden_d = hidden_q;
    if (tick_q) begin
      cnt_d = cnt_q + 8'd1;
      // A dropped enable overrides any step that would fall on the same tick.
      if (abort) begin
        state_d  = (level_q == 2'd0) ? ST_OFF : ST_FADE_OUT;
        cnt_d    = '0;
        hidden_d = 1'b0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            level_d = '0;
            if (!enable) begin
              cnt_d = '0;
            end else if (cnt_q == OFF_LAST) begin
              state_d = ST_FADE_IN;
              level_d = 2'd1;
              cnt_d   = '0;
            end
          end
          ST_FADE_IN: begin
            if (cnt_q == STEP_LAST) begin
              cnt_d = '0;
              if (level_q == 2'd3) state_d = ST_HOLD;
              else                 level_d = level_q + 2'd1;
            end
          end
          ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_d  = ST_BLINK;
              cnt_d    = '0;
              blink_d  = '0;
              hidden_d = 1'b0;
            end
          end
          ST_BLINK: begin
            if (cnt_q == HALF_LAST) begin
              cnt_d = '0;
              if (!hidden_q) begin
                hidden_d = 1'b1;
              end else begin
                hidden_d = 1'b0;
                if (blink_q == BLINK_LAST) state_d = ST_FADE_OUT;
                else                       blink_d = blink_q + 8'd1;
              end
            end
          end
          ST_FADE_OUT: begin
            if (cnt_q == STEP_LAST) begin
              cnt_d = '0;
              if (level_q == 2'd0) state_d = ST_OFF;
              else                 level_d = level_q - 2'd1;
            end
          end
          default: begin
            state_d = ST_OFF;
            level_d = '0;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    emblem_vis = emblem_draw & (state_q != ST_OFF) & ~((state_q == ST_BLINK) & hidden_q);
    rgb_d      = bg_rgb;
    if (!active)         rgb_d = COLOR_BLACK;
    else if (text_draw)  rgb_d = text_rgb;
    else if (emblem_vis) rgb_d = dim_rgb;
  end

  assign rgb_out    = rgb_q;
  assign state_out  = state_q;
  assign level_out  = level_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_overlay_sequencer.sv
// Randomized bench for overlay_sequencer with a frame-schedule reference model and scoreboard.
module tb_overlay_sequencer;

  localparam int unsigned P_OFF  = 2;
  localparam int unsigned P_STEP = 1;
  localparam int unsigned P_HOLD = 2;
  localparam int unsigned P_HALF = 1;
  localparam int unsigned P_BCNT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b1;
  logic       enable = 1'b0;
  logic       active = 1'b0;
  logic       emblem_draw = 1'b0;
  logic [5:0] emblem_rgb = '0;
  logic       text_draw = 1'b0;
  logic [5:0] text_rgb = '0;
  logic [5:0] bg_rgb = '0;
  logic [5:0] rgb_out;
  logic [2:0] state_out;
  logic [1:0] level_out;
  logic       frame_tick;

  always #5 clk = ~clk;

  overlay_sequencer #(
    .OFF_FRAMES       (P_OFF),
    .FADE_STEP_FRAMES (P_STEP),
    .HOLD_FRAMES      (P_HOLD),
    .BLINK_HALF       (P_HALF),
    .BLINK_COUNT      (P_BCNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .enable      (enable),
    .active      (active),
    .emblem_draw (emblem_draw),
    .emblem_rgb  (emblem_rgb),
    .text_draw   (text_draw),
    .text_rgb    (text_rgb),
    .bg_rgb      (bg_rgb),
    .rgb_out     (rgb_out),
    .state_out   (state_out),
    .level_out   (level_out),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    int         due;
    logic [5:0] rgb;
    logic [2:0] st;
    logic [1:0] lv;
    logic       tk;
  } exp_t;

  // One entry per frame the emblem will spend in a given (state, level, hidden) look.
  typedef struct {
    int st;
    int lv;
    bit hid;
  } frm_t;

  exp_t sbq[$];
  frm_t sched[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   vs_prev = 1'b1;
  bit   tick_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void add_frames(int st, int lv, bit hid, int n);
    frm_t f;
    f.st = st; f.lv = lv; f.hid = hid;
    for (int i = 0; i < n; i++) sched.push_back(f);
  endfunction

  function automatic void append_fade(int from);
    for (int l = from; l >= 0; l--) add_frames(4, l, 1'b0, int'(P_STEP));
  endfunction

  function automatic void build_cycle();
    add_frames(0, 0, 1'b0, int'(P_OFF));
    for (int l = 1; l <= 3; l++) add_frames(1, l, 1'b0, int'(P_STEP));
    add_frames(2, 3, 1'b0, int'(P_HOLD));
    for (int k = 0; k < int'(P_BCNT); k++) begin
      add_frames(3, 3, 1'b0, int'(P_HALF));
      add_frames(3, 3, 1'b1, int'(P_HALF));
    end
    append_fade(3);
  endfunction

  function automatic void model_tick(bit en);
    frm_t cur;
    cur = sched[0];
    if (cur.st == 0 && !en) begin
      sched.delete();
      build_cycle();
    end else if (!en && (cur.st inside {1, 2, 3})) begin
      sched.delete();
      if (cur.lv != 0) append_fade(cur.lv);
      build_cycle();
    end else begin
      void'(sched.pop_front());
      if (sched.size() == 0) build_cycle();
    end
  endfunction

  function automatic logic [5:0] exp_pixel(logic act, logic td, logic [5:0] trgb, logic ed,
                                           logic [5:0] ergb, logic [5:0] bg, frm_t f);
    int c, d, r;
    if (!act) return 6'h00;
    if (td) return trgb;
    if (ed && f.st != 0 && !(f.st == 3 && f.hid)) begin
      r = 0;
      for (int k = 0; k < 3; k++) begin
        c = (int'(ergb) >> (2 * k)) & 3;
        d = c - (3 - f.lv);
        if (d < 0) d = 0;
        r = r + (d << (2 * k));
      end
      return 6'(r);
    end
    return bg;
  endfunction

  task automatic step(input bit r, input bit v, input bit en);
    exp_t e;
    int   mode;
    @(posedge clk);
    #1;
    rst    = r;
    vsync  = v;
    enable = en;
    mode   = $urandom_range(0, 7);
    active = ($urandom_range(0, 7) != 0);
    text_draw   = ($urandom_range(0, 3) == 0);
    emblem_draw = ($urandom_range(0, 3) != 0);
    text_rgb    = 6'($urandom);
    emblem_rgb  = 6'($urandom);
    bg_rgb      = 6'($urandom);
    case (mode)
      0: begin active = 1'b1; emblem_draw = 1'b1; text_draw = 1'b0; emblem_rgb = 6'b110110; end
      1: begin active = 1'b1; emblem_draw = 1'b1; text_draw = 1'b1; text_rgb = 6'h3F; end
      2: active = 1'b0;
      3: begin active = 1'b1; emblem_draw = 1'b1; text_draw = 1'b0; bg_rgb = 6'h05; end
      default: ;
    endcase
    e.due = cyc + 1;
    if (r) begin
      e.rgb = 6'h00; e.st = 3'd0; e.lv = 2'd0; e.tk = 1'b0;
      sched.delete();
      build_cycle();
      vs_prev  = 1'b1;
      tick_now = 1'b0;
    end else begin
      e.rgb = exp_pixel(active, text_draw, text_rgb, emblem_draw, emblem_rgb, bg_rgb, sched[0]);
      e.tk  = vs_prev & ~v;
      if (tick_now) model_tick(en);
      e.st     = 3'(sched[0].st);
      e.lv     = 2'(sched[0].lv);
      tick_now = e.tk;
      vs_prev  = v;
    end
    sbq.push_back(e);
  endtask

  task automatic frame(input int len, input bit en);
    for (int i = 0; i < len; i++) step(1'b0, (i >= 2), en);
  endtask

  task automatic run_until(input int st, input int max_frames);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_frames; i++) begin
      if (sched[0].st == st) begin
        hit = 1'b1;
        break;
      end
      frame(10, 1'b1);
    end
    if (!hit && sched[0].st != st) begin
      total++;
      bad++;
      $display("FAIL reach_state: state %0d not reached within %0d frames, required %0d", sched[0].st, max_frames, st);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv, input int due);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", nm, due, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        chk("rgb_out", 8'(rgb_out), 8'(e.rgb), e.due);
        chk("state_out", 8'(state_out), 8'(e.st), e.due);
        chk("level_out", 8'(level_out), 8'(e.lv), e.due);
        chk("frame_tick", 8'(frame_tick), 8'(e.tk), e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_cycle();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    // full cycle with enable held high
    for (int i = 0; i < 18; i++) frame(10, 1'b1);
    // abort from HOLD, then re-enable partway through the fade
    run_until(2, 30);
    frame(10, 1'b0);
    frame(10, 1'b0);
    for (int i = 0; i < 6; i++) frame(10, 1'b1);
    // enable low in OFF keeps the sequencer parked
    run_until(0, 30);
    for (int i = 0; i < 4; i++) frame(10, 1'b0);
    // reset in the middle of BLINK, mid-frame
    run_until(3, 30);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) frame(10, 1'b1);
    // random frame lengths and enable patterns
    for (int i = 0; i < 60; i++) frame(int'($urandom_range(4, 14)), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
